// File: rtl/parking_pkg.sv
// Shared definitions for the keypad entry controller: key codes, FSM state
// encoding, parameter defaults and a small helper for sizing counters.
// No ports.
package parking_pkg;

    localparam int DEF_TIMEOUT_CYCLES = 500;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 1000;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE        = 3'd0;
    localparam state_t ST_COLLECT     = 3'd1;
    localparam state_t ST_SUBMIT      = 3'd2;
    localparam state_t ST_WAIT_RESULT = 3'd3;
    localparam state_t ST_LOCKOUT     = 3'd4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad entry bus: key strobe/code and checker verdict going in, assembled
// digits, submit pulse and status pulses coming out.
//   master : keypad/checker side (drives key_valid, key_code, unlock)
//   slave  : keypad_entry controller
interface keypad_entry_if;

    logic       key_valid;
    logic [3:0] key_code;
    logic       unlock;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       lock_input;
    logic [1:0] digit_count;
    logic       access_ok;
    logic       entry_error;
    logic       locked_out;

    modport master (
        output key_valid, key_code, unlock,
        input  digit1, digit2, digit3, lock_input, digit_count,
               access_ok, entry_error, locked_out
    );

    modport slave (
        input  key_valid, key_code, unlock,
        output digit1, digit2, digit3, lock_input, digit_count,
               access_ok, entry_error, locked_out
    );

endinterface

// File: rtl/entry_timer.sv
// Loadable down-counter shared by the inactivity timeout and the lockout.
//   clk, rst   : clock, asynchronous active-low reset
//   load       : load load_value (has priority over tick)
//   load_value : start value; done rises after load_value further ticks
//   tick       : decrement by one, holds at zero
//   done       : count is zero
module entry_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/keypad_entry.sv
// Three-digit keypad entry controller with submit handshake, inactivity
// timeout and lockout after repeated rejected codes.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : keypad_entry_if.slave (keys/verdict in, digits/pulses out)
//
// state          | meaning
// ST_IDLE        | no digits held, waiting for first digit
// ST_COLLECT     | 1-3 digits held, inactivity timer running
// ST_SUBMIT      | lock_input high for one cycle, digits stable
// ST_WAIT_RESULT | sample unlock verdict, update fail count
// ST_LOCKOUT     | locked_out high, keys dropped, lockout timer running
module keypad_entry
    import parking_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input logic           clk,
    input logic           rst,
    keypad_entry_if.slave bus
);

    localparam int TMAX = max_int(TIMEOUT_CYCLES, LOCKOUT_CYCLES);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int FW   = $clog2(MAX_FAILS + 1);

    // The timer signals done on the cycle it reaches zero, so load N-1 to
    // get an N-cycle window.
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_LIMIT   = FW'(MAX_FAILS);

    state_t          state, state_nx;
    logic [3:0]      d1, d2, d3, d1_nx, d2_nx, d3_nx;
    logic [1:0]      cnt, cnt_nx;
    logic [FW-1:0]   fails, fails_nx;
    logic            lock_q, ok_q, err_q, locked_q;
    logic            ok_nx, err_nx;
    logic            key_live, key_digit;
    logic            t_load, t_tick, t_done;
    logic [TW-1:0]   t_value;

    // Codes 0xC-0xF never count as activity.
    assign key_live  = bus.key_valid && (bus.key_code <= KEY_ENTER);
    assign key_digit = key_live && (bus.key_code <= 4'd9);

    entry_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (t_load),
        .load_value (t_value),
        .tick       (t_tick),
        .done       (t_done)
    );

    always_comb begin
        state_nx = state;
        d1_nx    = d1;
        d2_nx    = d2;
        d3_nx    = d3;
        cnt_nx   = cnt;
        fails_nx = fails;
        ok_nx    = 1'b0;
        err_nx   = 1'b0;
        t_load   = 1'b0;
        t_value  = TIMEOUT_LOAD;
        t_tick   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (key_digit) begin
                    d1_nx    = bus.key_code;
                    cnt_nx   = 2'd1;
                    t_load   = 1'b1;
                    state_nx = ST_COLLECT;
                end else if (key_live && (bus.key_code == KEY_CLEAR)) begin
                    {d1_nx, d2_nx, d3_nx} = '0;
                    cnt_nx = 2'd0;
                end
            end
            ST_COLLECT: begin
                if (key_live) begin
                    // Any accepted key, even a surplus fourth digit,
                    // restarts the inactivity window; it also beats a
                    // timeout landing on the same cycle.
                    t_load = 1'b1;
                    if (key_digit) begin
                        case (cnt)
                            2'd1: begin
                                d2_nx  = bus.key_code;
                                cnt_nx = 2'd2;
                            end
                            2'd2: begin
                                d3_nx  = bus.key_code;
                                cnt_nx = 2'd3;
                            end
                            default: ;
                        endcase
                    end else if (bus.key_code == KEY_CLEAR) begin
                        {d1_nx, d2_nx, d3_nx} = '0;
                        cnt_nx   = 2'd0;
                        state_nx = ST_IDLE;
                    end else if (cnt == 2'd3) begin
                        state_nx = ST_SUBMIT;
                    end else begin
                        err_nx   = 1'b1;
                        {d1_nx, d2_nx, d3_nx} = '0;
                        cnt_nx   = 2'd0;
                        state_nx = ST_IDLE;
                    end
                end else if (t_done) begin
                    err_nx   = 1'b1;
                    {d1_nx, d2_nx, d3_nx} = '0;
                    cnt_nx   = 2'd0;
                    state_nx = ST_IDLE;
                end else begin
                    t_tick = 1'b1;
                end
            end
            ST_SUBMIT: begin
                state_nx = ST_WAIT_RESULT;
            end
            ST_WAIT_RESULT: begin
                {d1_nx, d2_nx, d3_nx} = '0;
                cnt_nx = 2'd0;
                if (bus.unlock) begin
                    ok_nx    = 1'b1;
                    fails_nx = '0;
                    state_nx = ST_IDLE;
                end else begin
                    err_nx   = 1'b1;
                    fails_nx = (fails == FAIL_LIMIT) ? fails : fails + FW'(1);
                    if (fails_nx == FAIL_LIMIT) begin
                        t_load   = 1'b1;
                        t_value  = LOCKOUT_LOAD;
                        state_nx = ST_LOCKOUT;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (t_done) begin
                    fails_nx = '0;
                    state_nx = ST_IDLE;
                end else begin
                    t_tick = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            d1       <= '0;
            d2       <= '0;
            d3       <= '0;
            cnt      <= '0;
            fails    <= '0;
            lock_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_nx;
            d1       <= d1_nx;
            d2       <= d2_nx;
            d3       <= d3_nx;
            cnt      <= cnt_nx;
            fails    <= fails_nx;
            lock_q   <= (state_nx == ST_SUBMIT);
            ok_q     <= ok_nx;
            err_q    <= err_nx;
            locked_q <= (state_nx == ST_LOCKOUT);
        end
    end

    assign bus.digit1      = d1;
    assign bus.digit2      = d2;
    assign bus.digit3      = d3;
    assign bus.digit_count = cnt;
    assign bus.lock_input  = lock_q;
    assign bus.access_ok   = ok_q;
    assign bus.entry_error = err_q;
    assign bus.locked_out  = locked_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios followed by random key traffic,
// all outputs compared every cycle against a behavioural model built on a
// digit queue, an idle-cycle count and a lockout countdown.
module tb_keypad_entry;
    import parking_pkg::*;

    localparam int T_OUT = 500;
    localparam int M_F   = 3;
    localparam int L_C   = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    keypad_entry_if bus ();

    keypad_entry #(
        .TIMEOUT_CYCLES (T_OUT),
        .MAX_FAILS      (M_F),
        .LOCKOUT_CYCLES (L_C)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    int m_digits[$];
    int m_idle;
    int m_fails;
    int m_lock_left;
    bit m_submitting;
    bit m_judging;
    bit e_ok;
    bit e_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_digits.delete();
        m_idle       = 0;
        m_fails      = 0;
        m_lock_left  = 0;
        m_submitting = 1'b0;
        m_judging    = 1'b0;
        e_ok         = 1'b0;
        e_err        = 1'b0;
    endfunction

    function automatic void model_step(input bit kv, input logic [3:0] kc, input bit ul);
        bit live;
        live  = kv && (kc <= 4'hB);
        e_ok  = 1'b0;
        e_err = 1'b0;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (m_judging) begin
            m_judging = 1'b0;
            m_digits.delete();
            if (ul) begin
                e_ok    = 1'b1;
                m_fails = 0;
            end else begin
                e_err = 1'b1;
                if (m_fails < M_F) m_fails++;
                if (m_fails == M_F) m_lock_left = L_C;
            end
        end else if (m_submitting) begin
            m_submitting = 1'b0;
            m_judging    = 1'b1;
        end else if (m_digits.size() > 0) begin
            if (live) begin
                m_idle = 0;
                if (kc <= 4'd9) begin
                    if (m_digits.size() < 3) m_digits.push_back(int'(kc));
                end else if (kc == 4'hA) begin
                    m_digits.delete();
                end else if (m_digits.size() == 3) begin
                    m_submitting = 1'b1;
                end else begin
                    e_err = 1'b1;
                    m_digits.delete();
                end
            end else if (m_idle == T_OUT - 1) begin
                e_err = 1'b1;
                m_digits.delete();
            end else begin
                m_idle++;
            end
        end else if (live && (kc <= 4'd9)) begin
            m_digits.push_back(int'(kc));
            m_idle = 0;
        end
    endfunction

    function automatic int exp_digit(input int i);
        return (i < m_digits.size()) ? m_digits[i] : 0;
    endfunction

    task automatic compare_all();
        check("digit1",      bus.digit1,      exp_digit(0));
        check("digit2",      bus.digit2,      exp_digit(1));
        check("digit3",      bus.digit3,      exp_digit(2));
        check("digit_count", bus.digit_count, m_digits.size());
        check("lock_input",  bus.lock_input,  m_submitting);
        check("access_ok",   bus.access_ok,   e_ok);
        check("entry_error", bus.entry_error, e_err);
        check("locked_out",  bus.locked_out,  m_lock_left > 0);
    endtask

    // Called at a falling edge: apply inputs, advance one clock, compare.
    task automatic cycle(input bit kv, input logic [3:0] kc, input bit ul);
        bus.key_valid = kv;
        bus.key_code  = kc;
        bus.unlock    = ul;
        @(posedge clk);
        model_step(kv, kc, ul);
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input logic [3:0] kc);
        cycle(1'b1, kc, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'($urandom), 1'b0);
    endtask

    task automatic submit_and_judge(input int a, input int b, input int c, input bit ul);
        press(4'(a));
        press(4'(b));
        press(4'(c));
        press(KEY_ENTER);
        cycle(1'b0, 4'h0, 1'b0);
        cycle(1'b0, 4'h0, ul);
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check({tag, "_digit1"},      bus.digit1,      0);
        check({tag, "_digit2"},      bus.digit2,      0);
        check({tag, "_digit3"},      bus.digit3,      0);
        check({tag, "_digit_count"}, bus.digit_count, 0);
        check({tag, "_lock_input"},  bus.lock_input,  0);
        check({tag, "_access_ok"},   bus.access_ok,   0);
        check({tag, "_entry_error"}, bus.entry_error, 0);
        check({tag, "_locked_out"},  bus.locked_out,  0);
        model_reset();
        bus.key_valid = 1'b0;
        bus.unlock    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.unlock    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b1;

        // Accepted three-digit code
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(KEY_ENTER);
        check("ok_lock_pulse", bus.lock_input, 1);
        check("ok_digits", {bus.digit1, bus.digit2, bus.digit3}, 12'h123);
        cycle(1'b0, 4'h0, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        check("ok_access", bus.access_ok, 1);

        // Short entry
        press(4'd1);
        press(4'd2);
        press(KEY_ENTER);
        check("short_err", bus.entry_error, 1);
        check("short_count", bus.digit_count, 0);
        idle(2);

        // Fourth digit ignored, then clear without error
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        press(KEY_ENTER);
        check("four_digit3", bus.digit3, 3);
        cycle(1'b0, 4'h0, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        press(4'd1);
        press(4'd2);
        press(KEY_CLEAR);
        check("clear_count", bus.digit_count, 0);
        check("clear_no_err", bus.entry_error, 0);

        // Inactivity timeout boundary
        press(4'd5);
        idle(T_OUT - 1);
        check("timeout_alive", bus.digit_count, 1);
        idle(1);
        check("timeout_err", bus.entry_error, 1);
        check("timeout_cleared", bus.digit1, 0);
        press(4'd5);
        idle(T_OUT - 1);
        press(4'd6);
        check("timeout_key_wins", bus.digit_count, 2);
        press(4'hE);
        press(KEY_CLEAR);

        // Lockout after three rejections, keys dropped while locked
        for (int r = 0; r < M_F; r++) begin
            submit_and_judge(9, 9, 9, 1'b0);
            check("reject_err", bus.entry_error, 1);
        end
        check("lockout_on", bus.locked_out, 1);
        for (int i = 0; i < L_C - 1; i++) cycle(1'b1, 4'($urandom), 1'b1);
        check("lockout_last", bus.locked_out, 1);
        idle(1);
        check("lockout_exit", bus.locked_out, 0);
        press(4'd7);
        check("after_lock_entry", bus.digit_count, 1);
        press(KEY_CLEAR);

        // Reset during lockout and during collection
        for (int r = 0; r < M_F; r++) submit_and_judge(8, 8, 8, 1'b0);
        idle(100);
        pulse_reset("rst_lockout");
        press(4'd4);
        check("rst_fresh_entry", bus.digit_count, 1);
        press(4'd2);
        pulse_reset("rst_collect");
        submit_and_judge(3, 1, 4, 1'b1);
        check("rst_then_ok", bus.access_ok, 1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [3:0] kc;
            if (i == 2000) pulse_reset("rst_random");
            if ($urandom_range(0, 399) == 0) begin
                int n;
                n = $urandom_range(T_OUT - 5, T_OUT + 5);
                for (int j = 0; j < n; j++) cycle(1'b0, 4'($urandom), 1'($urandom));
            end else begin
                r = $urandom_range(0, 15);
                if (r < 10)       kc = 4'(r);
                else if (r < 12)  kc = KEY_ENTER;
                else if (r == 12) kc = KEY_CLEAR;
                else              kc = 4'(r);
                cycle(($urandom_range(0, 2) == 0), kc, 1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 500, idle cycles allowed between keys during entry before abort.
REQ-002 Parameter MAX_FAILS, default 3, consecutive rejected submissions that trigger lockout.
REQ-003 Parameter LOCKOUT_CYCLES, default 1000, duration of lockout.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 key_valid  input  1  one-cycle strobe: key_code valid this cycle.
REQ-007 key_code  input  4  0x0-0x9 digit, 0xA clear, 0xB enter, 0xC-0xF ignored.
REQ-008 unlock  input  1  verdict from downstream checker, valid the cycle after lock_input.
REQ-009 digit1, digit2, digit3  output  4 each  assembled digits, first-entered in digit1.
REQ-010 lock_input  output  1  one-cycle submit pulse to checker.
REQ-011 digit_count  output  2  digits held, 0-3.
REQ-012 access_ok  output  1  one-cycle pulse: submission accepted.
REQ-013 entry_error  output  1  one-cycle pulse: short entry, timeout or rejected code.
REQ-014 locked_out  output  1  high throughout LOCKOUT.

Function
REQ-015 FSM states SHALL be IDLE, COLLECT, SUBMIT, WAIT_RESULT, LOCKOUT; all outputs registered.
REQ-016 IDLE + digit key: store in digit1, digit_count=1, go COLLECT.
REQ-017 COLLECT + digit key with digit_count<3: store in next slot, increment count; with digit_count==3: ignore key, no state change.
REQ-018 COLLECT + enter with digit_count==3: go SUBMIT; with digit_count<3: pulse entry_error, clear digits, go IDLE.
REQ-019 Clear key in IDLE/COLLECT: zero digits and count, go IDLE, no error pulse.
REQ-020 SUBMIT lasts exactly one cycle with lock_input=1 and digits stable; next state WAIT_RESULT.
REQ-021 WAIT_RESULT lasts exactly one cycle and samples unlock: 1 -> pulse access_ok, fail count=0, go IDLE; 0 -> pulse entry_error, fail count+1, go LOCKOUT if new count==MAX_FAILS else IDLE; digits zeroed either way.
REQ-022 Inactivity timer counts cycles in COLLECT without key_valid; reset by any key_valid; at TIMEOUT_CYCLES-1 -> pulse entry_error, clear digits, go IDLE.
REQ-023 LOCKOUT: locked_out=1, all keys ignored, exit to IDLE after exactly LOCKOUT_CYCLES cycles, fail count cleared on exit.
REQ-024 key_valid in SUBMIT, WAIT_RESULT, LOCKOUT SHALL be dropped, not buffered.
REQ-025 Codes 0xC-0xF SHALL be ignored in every state and do not reset the inactivity timer.
REQ-026 Fail counter saturates at MAX_FAILS; width ceil(log2(MAX_FAILS+1)).
REQ-027 Timeout and key on same cycle: key wins, timer restarts.

Reset
REQ-028 rst low SHALL immediately force IDLE, digits=0, digit_count=0, lock_input=0, access_ok=0, entry_error=0, locked_out=0, fail count=0, timers=0, including mid-entry and mid-lockout.

Structure
REQ-029 Key code constants (KEY_CLEAR, KEY_ENTER), state typedef and parameter defaults SHALL live in shared package parking_pkg.
REQ-030 One sub-module entry_timer (loadable down-counter, done flag) SHALL be instantiated for both inactivity timeout and lockout.

Verification
REQ-031 Keys 1,2,3,enter; unlock=1 cycle after lock_input -> lock_input one cycle with digits 1/2/3, access_ok pulse next cycle.
REQ-032 Keys 1,2,enter -> entry_error pulse, no lock_input, digit_count=0.
REQ-033 Three submissions of 9,9,9 with unlock=0 -> three entry_error pulses, locked_out=1 for 1000 cycles, keys ignored, then IDLE.
REQ-034 Key 5 then 500 idle cycles -> entry_error, digits cleared; key at cycle 499 keeps entry alive.
REQ-035 Keys 1,2,3,4,enter -> fourth digit ignored, submitted 1/2/3; clear after 1,2 -> count 0, no error.
REQ-036 rst low during LOCKOUT and during COLLECT -> all outputs zero immediately, fresh entry accepted after release.
